// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: request sizes, FSM
// states, port ids, the transaction latched at acceptance, and byte-enable/legality rules.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Everything RESP needs, captured at acceptance so the live inputs may change.
  typedef struct packed {
    port_e      port;
    logic       we;
    logic [2:0] size;
    logic [1:0] addr_lo;
    logic       err;
  } txn_s;

  function automatic logic [3:0] gen_be(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_B, SZ_BU: be = 4'b0001 << addr_lo;
      SZ_H, SZ_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
      SZ_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Unsigned sizes exist only for loads; halves and words must be naturally aligned.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] addr_lo,
                                     input logic we);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_BU:   ok = !we;
      SZ_H:    ok = !addr_lo[0];
      SZ_HU:   ok = !addr_lo[0] && !we;
      SZ_W:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request handshake plus the
// single-cycle response pulse. The requester is master, the arbiter is slave.
interface dmem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Combinational lane logic: store-side byte enables and data replication,
// load-side lane extraction with sign/zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  rd_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = ld_word[8*gi +: 8];
  end

  always_comb begin
    st_be = gen_be(st_size, st_addr_lo);
    case (st_size)
      SZ_B, SZ_BU: st_wdata_rep = {4{st_wdata[7:0]}};
      SZ_H, SZ_HU: st_wdata_rep = {2{st_wdata[15:0]}};
      default:     st_wdata_rep = st_wdata;
    endcase
  end

  always_comb begin
    ld_byte = rd_lane[ld_addr_lo];
    ld_half = {rd_lane[{ld_addr_lo[1], 1'b1}], rd_lane[{ld_addr_lo[1], 1'b0}]};
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_data = {24'b0, ld_byte};
      SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_data = {16'b0, ld_half};
      SZ_W:    ld_data = ld_word;
      default: ld_data = 32'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one single-ported data
// memory between the core LSU (c_port) and the DMA/debug engine (d_port).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_arbiter_if.slave        c_port,
  dmem_arbiter_if.slave        d_port,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  arb_state_e state_q, state_d;
  port_e      last_grant_q, last_grant_d;
  txn_s       txn_q, txn_d;

  logic        gnt_c;
  logic        accept;
  port_e       sel_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [2:0]  sel_size;
  logic [31:0] sel_wdata;
  logic        sel_legal;

  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;
  logic        rsp_live;
  logic [31:0] rsp_data;

  // Address bits above the memory depth are deliberately dropped (wrap-around).
  logic unused_hi_addr;
  assign unused_hi_addr = ^sel_addr[31:AW+2];

  // Grant selection: C wins unless D is also asking and C had the last turn.
  always_comb begin
    gnt_c     = c_port.req_valid && (!d_port.req_valid || last_grant_q == PORT_D);
    accept    = (state_q == IDLE) && !reset && (c_port.req_valid || d_port.req_valid);
    sel_port  = gnt_c ? PORT_C : PORT_D;
    sel_we    = gnt_c ? c_port.req_we    : d_port.req_we;
    sel_addr  = gnt_c ? c_port.req_addr  : d_port.req_addr;
    sel_size  = gnt_c ? c_port.req_size  : d_port.req_size;
    sel_wdata = gnt_c ? c_port.req_wdata : d_port.req_wdata;
    sel_legal = req_legal(sel_size, sel_addr[1:0], sel_we);
  end

  dmem_lane_fmt u_lane_fmt (
    .st_size      (sel_size),
    .st_addr_lo   (sel_addr[1:0]),
    .st_wdata     (sel_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (txn_q.size),
    .ld_addr_lo   (txn_q.addr_lo),
    .ld_word      (mem_rdata),
    .ld_data      (ld_data)
  );

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    txn_d        = txn_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = RESP;
          last_grant_d  = sel_port;
          txn_d.port    = sel_port;
          txn_d.we      = sel_we;
          txn_d.size    = sel_size;
          txn_d.addr_lo = sel_addr[1:0];
          txn_d.err     = !sel_legal;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      txn_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      txn_q        <= txn_d;
    end
  end

  // Outputs; reset forces every output low, which also drops an in-flight response.
  always_comb begin
    c_port.req_ready = accept && (sel_port == PORT_C);
    d_port.req_ready = accept && (sel_port == PORT_D);

    mem_en    = accept && sel_legal;
    mem_we    = mem_en && sel_we;
    mem_be    = mem_en ? st_be : 4'b0;
    mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
    mem_wdata = mem_we ? st_wdata_rep : 32'b0;

    rsp_live  = (state_q == RESP) && !reset;
    rsp_data  = (txn_q.err || txn_q.we) ? 32'b0 : ld_data;

    c_port.rsp_valid = rsp_live && (txn_q.port == PORT_C);
    d_port.rsp_valid = rsp_live && (txn_q.port == PORT_D);
    c_port.rsp_rdata = c_port.rsp_valid ? rsp_data : 32'b0;
    d_port.rsp_rdata = d_port.rsp_valid ? rsp_data : 32'b0;
    c_port.rsp_err   = c_port.rsp_valid && txn_q.err;
    d_port.rsp_err   = d_port.rsp_valid && txn_q.err;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-level reference model checked every cycle,
// plus directed transactions with hand-computed expectations.
module tb_dmem_arbiter;

  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if c_if ();
  dmem_arbiter_if d_if ();

  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  dmem_arbiter #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .c_port    (c_if),
    .d_port    (d_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory array behind the DUT; cleared while reset is held.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'b0;
      mem_rdata <= 32'b0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  logic [7:0]  mb [NBYTES];
  bit          m_busy = 0;
  int          m_last = 1;
  int          m_port = 0;
  bit          m_err = 0;
  logic [31:0] m_rdata = 0;

  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit legal(input logic we, input int a, input logic [2:0] sz);
    case (sz)
      3'd0:    return 1;
      3'd4:    return !we;
      3'd1:    return (a % 2) == 0;
      3'd5:    return ((a % 2) == 0) && !we;
      3'd2:    return (a % 4) == 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input int a, input logic [2:0] sz);
    logic [31:0] v = 32'b0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[a+i];
    if (sz == 3'd0 && v[7])  v[31:8]  = '1;
    if (sz == 3'd1 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  always @(negedge clk) begin : model
    int win, a, n;
    logic mwe;
    logic [2:0] msz;
    logic [31:0] mwd;
    bit lg;
    logic e_rc, e_rd, e_en, e_we, e_cv, e_dv;
    logic [3:0] e_be;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wd;
    win = -1; a = 0; n = 1; mwe = 0; msz = 0; mwd = 0; lg = 0;
    e_rc = 0; e_rd = 0; e_en = 0; e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
    if (!reset && !m_busy) begin
      if (c_if.req_valid && (!d_if.req_valid || m_last == 1)) win = 0;
      else if (d_if.req_valid) win = 1;
      if (win == 0) begin
        mwe = c_if.req_we; msz = c_if.req_size; mwd = c_if.req_wdata;
        a = int'(c_if.req_addr % NBYTES);
      end else if (win == 1) begin
        mwe = d_if.req_we; msz = d_if.req_size; mwd = d_if.req_wdata;
        a = int'(d_if.req_addr % NBYTES);
      end
      if (win >= 0) begin
        n = nbytes(msz);
        lg = legal(mwe, a, msz);
        e_rc = (win == 0);
        e_rd = (win == 1);
        if (lg) begin
          e_en = 1; e_we = mwe;
          e_be = 4'(((1 << n) - 1) << (a % 4));
          e_addr = AW'(a / 4);
          if (mwe) e_wd = (n == 1) ? {4{mwd[7:0]}} : (n == 2) ? {2{mwd[15:0]}} : mwd;
        end
      end
    end
    e_cv = !reset && m_busy && m_port == 0;
    e_dv = !reset && m_busy && m_port == 1;

    chk("c_req_ready", c_if.req_ready, e_rc);
    chk("d_req_ready", d_if.req_ready, e_rd);
    chk("mem_en", mem_en, e_en);
    if (e_en || reset) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_be", mem_be, e_be);
      chk("mem_addr", mem_addr, e_addr);
    end
    if (e_we || reset) chk("mem_wdata", mem_wdata, e_wd);
    chk("c_rsp_valid", c_if.rsp_valid, e_cv);
    chk("d_rsp_valid", d_if.rsp_valid, e_dv);
    if (e_cv || reset) begin
      chk("c_rsp_rdata", c_if.rsp_rdata, e_cv ? m_rdata : 32'b0);
      chk("c_rsp_err", c_if.rsp_err, e_cv && m_err);
    end
    if (e_dv || reset) begin
      chk("d_rsp_rdata", d_if.rsp_rdata, e_dv ? m_rdata : 32'b0);
      chk("d_rsp_err", d_if.rsp_err, e_dv && m_err);
    end

    if (reset) begin
      m_busy = 0; m_last = 1;
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    end else if (m_busy) begin
      m_busy = 0;
    end else if (win >= 0) begin
      m_busy = 1; m_last = win; m_port = win; m_err = !lg; m_rdata = 0;
      if (lg && mwe) for (int i = 0; i < n; i++) mb[a+i] = mwd[8*i +: 8];
      else if (lg) m_rdata = load_val(a, msz);
    end
  end

  // ---------------- directed stimulus ----------------
  logic          r_en_seen, r_rv, r_err;
  logic [3:0]    r_be;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata, r_rdata;

  task automatic set_req(input bit pd, input logic v, input logic we, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
    if (pd) begin
      d_if.req_valid = v; d_if.req_we = we; d_if.req_addr = a;
      d_if.req_size = sz; d_if.req_wdata = wd;
    end else begin
      c_if.req_valid = v; c_if.req_we = we; c_if.req_addr = a;
      c_if.req_size = sz; c_if.req_wdata = wd;
    end
  endtask

  task automatic xact(input bit pd, input logic we, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    bit done = 0;
    @(posedge clk); #1;
    set_req(pd, 1'b1, we, a, sz, wd);
    r_en_seen = 0; r_be = 0; r_addr = 0; r_wdata = 0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (pd ? d_if.req_ready : c_if.req_ready) begin
        done = 1; r_en_seen = mem_en; r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata;
      end
      @(posedge clk); #1;
    end
    set_req(pd, 1'b0, 1'b0, 32'b0, 3'b0, 32'b0);
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    r_rv    = pd ? d_if.rsp_valid : c_if.rsp_valid;
    r_rdata = pd ? d_if.rsp_rdata : c_if.rsp_rdata;
    r_err   = pd ? d_if.rsp_err   : c_if.rsp_err;
    $display("xact port=%s we=%0b addr=%h size=%0d wdata=%h -> en=%0b be=%b rsp=%0b rdata=%h err=%0b",
             pd ? "D" : "C", we, a, sz, wd, r_en_seen, r_be, r_rv, r_rdata, r_err);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] h_cr, h_dr, h_cv, h_dv;
    set_req(0, 1'b1, 1'b0, 32'h0, 3'b010, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h4, 3'b010, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Both ports requesting continuously from reset: C, D, C, D.
    h_cr = 0; h_dr = 0; h_cv = 0; h_dv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      h_cr[k] = c_if.req_ready; h_dr[k] = d_if.req_ready;
      h_cv[k] = c_if.rsp_valid; h_dv[k] = d_if.rsp_valid;
      $display("cycle %0d c_ready=%0b d_ready=%0b c_rsp=%0b d_rsp=%0b", k, h_cr[k], h_dr[k], h_cv[k], h_dv[k]);
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 32'b0, 3'b0, 32'b0);
    set_req(1, 1'b0, 1'b0, 32'b0, 3'b0, 32'b0);
    chk("rr_c_ready_hist", h_cr, 8'h11);
    chk("rr_d_ready_hist", h_dr, 8'h44);
    chk("rr_c_rsp_hist", h_cv, 8'h22);
    chk("rr_d_rsp_hist", h_dv, 8'h88);

    xact(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    chk("sw_be", r_be, 4'b1111); chk("sw_addr", r_addr, 6'd4);
    chk("sw_rsp", r_rv, 1); chk("sw_rdata", r_rdata, 0); chk("sw_err", r_err, 0);
    xact(0, 1'b0, 32'h10, 3'b010, 32'h0);
    chk("lw_be", r_be, 4'b1111); chk("lw_addr", r_addr, 6'd4);
    chk("lw_rdata", r_rdata, 32'hDEADBEEF); chk("lw_err", r_err, 0);

    xact(0, 1'b1, 32'h13, 3'b000, 32'h00000080);
    chk("sb_be", r_be, 4'b1000); chk("sb_wdata", r_wdata, 32'h80808080);
    xact(0, 1'b0, 32'h13, 3'b000, 32'h0);
    chk("lb_rdata", r_rdata, 32'hFFFFFF80);
    xact(0, 1'b0, 32'h13, 3'b100, 32'h0);
    chk("lbu_rdata", r_rdata, 32'h00000080);

    xact(0, 1'b0, 32'h11, 3'b001, 32'h0);
    chk("lh_mis_en", r_en_seen, 0); chk("lh_mis_err", r_err, 1); chk("lh_mis_rdata", r_rdata, 0);
    xact(0, 1'b0, 32'h12, 3'b010, 32'h0);
    chk("lw_mis_en", r_en_seen, 0); chk("lw_mis_err", r_err, 1); chk("lw_mis_rdata", r_rdata, 0);

    xact(1, 1'b1, 32'h20, 3'b010, 32'h12345678);
    xact(1, 1'b1, 32'h20, 3'b101, 32'h0000AAAA);
    chk("shu_en", r_en_seen, 0); chk("shu_err", r_err, 1); chk("shu_rsp", r_rv, 1);
    xact(1, 1'b1, 32'h20, 3'b011, 32'hFFFFFFFF);
    chk("s011_en", r_en_seen, 0); chk("s011_err", r_err, 1);
    xact(1, 1'b0, 32'h20, 3'b010, 32'h0);
    chk("readback_unchanged", r_rdata, 32'h12345678);

    xact(1, 1'b1, 32'h22, 3'b001, 32'h0000BEEF);
    chk("sh_be", r_be, 4'b1100); chk("sh_wdata", r_wdata, 32'hBEEFBEEF);
    xact(1, 1'b0, 32'h22, 3'b001, 32'h0);
    chk("lh_rdata", r_rdata, 32'hFFFFBEEF);
    xact(1, 1'b0, 32'h22, 3'b101, 32'h0);
    chk("lhu_rdata", r_rdata, 32'h0000BEEF);

    xact(0, 1'b0, 32'h110, 3'b010, 32'h0);
    chk("wrap_addr", r_addr, 6'd4); chk("wrap_rdata", r_rdata, 32'h80ADBEEF);

    // Reset during the response phase of a D load drops the response.
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b0, 32'h10, 3'b010, 32'h0);
    @(negedge clk);
    chk("rst_d_ready", d_if.req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(1, 1'b0, 1'b0, 32'b0, 3'b0, 32'b0);
    @(negedge clk);
    chk("rst_d_rsp_dropped", d_if.rsp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    $display("reset in RESP: d_rsp_valid=%0b mem_en=%0b", d_if.rsp_valid, mem_en);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 3'b010, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h4, 3'b010, 32'h0);
    @(negedge clk);
    chk("post_rst_c_first", c_if.req_ready, 1);
    chk("post_rst_d_wait", d_if.req_ready, 0);
    $display("after reset tie: c_ready=%0b d_ready=%0b", c_if.req_ready, d_if.req_ready);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'b0, 3'b0, 32'b0);
    set_req(1, 1'b0, 1'b0, 32'b0, 3'b0, 32'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
